// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  // Fetch unit side
  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  // Instruction memory side
  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to imem over a req/ack bus and
// produces pc/instructions/xiaoc for the IF/ID register. Honours the ID
// load-use stall and branch/jump redirects resolved in ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   loaduse,
  input  logic                   br_taken,
  input  logic [31:0]            br_target,
  input  logic                   jmp_en,
  input  logic [31:0]            jmp_target,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            pc,
  output logic [31:0]            instructions,
  output logic                   xiaoc
);

  typedef enum logic [1:0] {StFetch, StWait, StDrop, StHold} state_e;

  state_e      state_q;
  logic [31:0] pc_f_q;       // address of the next instruction to fetch
  logic [31:0] drop_addr_q;  // address of the in-flight wrong-path request
  logic [31:0] hold_pc_q;    // word captured while ID was stalled
  logic [31:0] hold_instr_q;

  logic        redir;
  logic [31:0] target;

  // Redirect decode; jumps win over branches, nothing redirects during a stall
  always_comb begin
    redir  = (jmp_en | br_taken) & ~loaduse;
    target = jmp_en ? jmp_target : br_target;
  end

  // Bus drive: no request during reset or while a stalled word is buffered
  always_comb begin
    imem.req  = ~rst & (state_q != StHold);
    imem.addr = (state_q == StDrop) ? drop_addr_q : pc_f_q;
  end

  // Fetch state machine with registered IF/ID outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_f_q       <= RESET_PC;
      drop_addr_q  <= 32'h0;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= 32'h0;
      pc           <= 32'h0;
      instructions <= 32'h0;
      xiaoc        <= 1'b1;
    end else begin
      unique case (state_q)
        StFetch, StWait: begin
          if (loaduse) begin
            // IF outputs frozen; park an arriving word until the stall lifts
            if (imem.ack) begin
              hold_pc_q    <= pc_f_q;
              hold_instr_q <= imem.rdata;
              pc_f_q       <= pc_f_q + 32'd4;
              state_q      <= StHold;
            end
          end else if (redir) begin
            pc_f_q <= target;
            xiaoc  <= 1'b1;
            if (imem.ack) begin
              state_q <= StFetch;
            end else begin
              // The outstanding request must complete before the new fetch
              drop_addr_q <= pc_f_q;
              state_q     <= StDrop;
            end
          end else if (imem.ack) begin
            pc           <= pc_f_q;
            instructions <= imem.rdata;
            xiaoc        <= 1'b0;
            pc_f_q       <= pc_f_q + 32'd4;
            state_q      <= StFetch;
          end else begin
            xiaoc   <= 1'b1;
            state_q <= StWait;
          end
        end
        StDrop: begin
          xiaoc <= 1'b1;
          if (redir) begin
            pc_f_q <= target;
          end
          if (imem.ack) begin
            state_q <= StFetch;
          end
        end
        StHold: begin
          if (!loaduse) begin
            if (redir) begin
              pc_f_q <= target;
              xiaoc  <= 1'b1;
            end else begin
              pc           <= hold_pc_q;
              instructions <= hold_instr_q;
              xiaoc        <= 1'b0;
            end
            state_q <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-configurable memory model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        loaduse = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        jmp_en = 1'b0;
  logic [31:0] jmp_target = 32'h0;
  logic [31:0] pc;
  logic [31:0] instructions;
  logic        xiaoc;

  int unsigned lat = 0;
  int unsigned wait_cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  if_fetch_unit_if imem ();

  if_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk          (clk),
    .rst          (rst),
    .loaduse      (loaduse),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_en       (jmp_en),
    .jmp_target   (jmp_target),
    .imem         (imem),
    .pc           (pc),
    .instructions (instructions),
    .xiaoc        (xiaoc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  // Memory: acks a request once it has been pending for lat cycles
  assign imem.ack   = imem.req && (wait_cnt >= lat);
  assign imem.rdata = word(imem.addr);

  always_ff @(posedge clk) begin
    if (rst || !imem.req || imem.ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state, and no request while rst is high
    step();
    check_eq("rst_req", {31'b0, imem.req}, 32'h0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_instr", instructions, 32'h0);
    check_eq("rst_xiaoc", {31'b0, xiaoc}, 32'h1);

    // Zero-wait memory: one instruction per clock
    rst = 1'b0;
    #1;
    check_eq("zw_req0", {31'b0, imem.req}, 32'h1);
    check_eq("zw_addr0", imem.addr, 32'h0000_3000);
    step();
    check_eq("zw_pc0", pc, 32'h0000_3000);
    check_eq("zw_instr0", instructions, word(32'h0000_3000));
    check_eq("zw_xiaoc0", {31'b0, xiaoc}, 32'h0);
    step();
    check_eq("zw_pc1", pc, 32'h0000_3004);
    step();
    check_eq("zw_pc2", pc, 32'h0000_3008);
    check_eq("zw_instr2", instructions, word(32'h0000_3008));

    // Two-cycle ack latency
    lat = 2;
    do_reset();
    step();
    check_eq("lat_x0", {31'b0, xiaoc}, 32'h1);
    step();
    check_eq("lat_x1", {31'b0, xiaoc}, 32'h1);
    step();
    check_eq("lat_pc0", pc, 32'h0000_3000);
    check_eq("lat_x2", {31'b0, xiaoc}, 32'h0);
    check_eq("lat_addr0", imem.addr, 32'h0000_3004);
    step();
    check_eq("lat_x3", {31'b0, xiaoc}, 32'h1);
    check_eq("lat_addr1", imem.addr, 32'h0000_3004);
    check_eq("lat_pc1", pc, 32'h0000_3000);
    step();
    check_eq("lat_x4", {31'b0, xiaoc}, 32'h1);
    check_eq("lat_addr2", imem.addr, 32'h0000_3004);
    step();
    check_eq("lat_pc2", pc, 32'h0000_3004);
    check_eq("lat_x5", {31'b0, xiaoc}, 32'h0);
    check_eq("lat_instr", instructions, word(32'h0000_3004));

    // Load-use stall for three cycles with an ack during the stall
    lat = 0;
    do_reset();
    step();
    step();
    loaduse = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("lu_pc", pc, 32'h0000_3004);
      check_eq("lu_instr", instructions, word(32'h0000_3004));
      check_eq("lu_xiaoc", {31'b0, xiaoc}, 32'h0);
      check_eq("lu_req", {31'b0, imem.req}, 32'h0);
    end
    loaduse = 1'b0;
    step();
    check_eq("lu_rel_pc", pc, 32'h0000_3008);
    check_eq("lu_rel_instr", instructions, word(32'h0000_3008));
    check_eq("lu_rel_xiaoc", {31'b0, xiaoc}, 32'h0);
    check_eq("lu_rel_addr", imem.addr, 32'h0000_300C);
    step();
    check_eq("lu_next_pc", pc, 32'h0000_300C);

    // Taken branch
    do_reset();
    step();
    br_taken  = 1'b1;
    br_target = 32'h0000_3100;
    step();
    br_taken = 1'b0;
    #1;
    check_eq("br_xiaoc", {31'b0, xiaoc}, 32'h1);
    check_eq("br_addr", imem.addr, 32'h0000_3100);
    step();
    check_eq("br_pc", pc, 32'h0000_3100);
    check_eq("br_instr", instructions, word(32'h0000_3100));
    check_eq("br_xiaoc2", {31'b0, xiaoc}, 32'h0);

    // Jump beats branch
    do_reset();
    step();
    br_taken   = 1'b1;
    br_target  = 32'h0000_3100;
    jmp_en     = 1'b1;
    jmp_target = 32'h0000_3200;
    step();
    br_taken = 1'b0;
    jmp_en   = 1'b0;
    #1;
    check_eq("jb_addr", imem.addr, 32'h0000_3200);
    check_eq("jb_xiaoc", {31'b0, xiaoc}, 32'h1);
    step();
    check_eq("jb_pc", pc, 32'h0000_3200);

    // Redirect during a wait: old request completes and is discarded
    do_reset();
    step();
    step();
    lat = 3;
    #1;
    step();
    check_eq("dr_wait_addr", imem.addr, 32'h0000_3008);
    br_taken  = 1'b1;
    br_target = 32'h0000_3400;
    step();
    br_taken = 1'b0;
    #1;
    check_eq("dr_addr0", imem.addr, 32'h0000_3008);
    check_eq("dr_req0", {31'b0, imem.req}, 32'h1);
    check_eq("dr_xiaoc0", {31'b0, xiaoc}, 32'h1);
    step();
    check_eq("dr_addr1", imem.addr, 32'h0000_3008);
    check_eq("dr_xiaoc1", {31'b0, xiaoc}, 32'h1);
    step();
    check_eq("dr_addr2", imem.addr, 32'h0000_3400);
    check_eq("dr_xiaoc2", {31'b0, xiaoc}, 32'h1);
    check_eq("dr_pc2", pc, 32'h0000_3004);
    lat = 0;
    #1;
    step();
    check_eq("dr_pc3", pc, 32'h0000_3400);
    check_eq("dr_xiaoc3", {31'b0, xiaoc}, 32'h0);

    // PC wraps modulo 2^32
    do_reset();
    step();
    jmp_en     = 1'b1;
    jmp_target = 32'hFFFF_FFFC;
    step();
    jmp_en = 1'b0;
    #1;
    step();
    check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
    check_eq("wrap_addr", imem.addr, 32'h0000_0000);

    // Reset while in HOLD
    do_reset();
    step();
    loaduse = 1'b1;
    step();
    check_eq("rh_req_hold", {31'b0, imem.req}, 32'h0);
    rst = 1'b1;
    step();
    check_eq("rh_pc", pc, 32'h0);
    check_eq("rh_instr", instructions, 32'h0);
    check_eq("rh_xiaoc", {31'b0, xiaoc}, 32'h1);
    rst     = 1'b0;
    loaduse = 1'b0;
    #1;
    check_eq("rh_req", {31'b0, imem.req}, 32'h1);
    check_eq("rh_addr", imem.addr, 32'h0000_3000);
    step();
    check_eq("rh_pc2", pc, 32'h0000_3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
